// File: rtl/spi_slave_regif.sv
// SPI slave front end for a register file: oversamples the SPI pins in the clk domain,
// decodes {header, address, data} frames and turns each into one register read or write.
module spi_slave_regif #(
  parameter int header  = 2,
  parameter int payload = 8,
  parameter int addrsz  = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sclk,
  input  logic               cs_n,
  input  logic               mosi,
  output logic               miso,
  output logic               miso_oe,
  output logic [addrsz-1:0]  reg_addr,
  output logic [payload-1:0] reg_wdata,
  output logic               reg_we,
  output logic               reg_re,
  input  logic [payload-1:0] reg_rdata,
  output logic               busy,
  output logic               frame_err
);

  localparam int pktsz = header + addrsz + payload;
  localparam logic [4:0]        HA_CNT  = 5'(header + addrsz);
  localparam logic [4:0]        PKT_CNT = 5'(pktsz);
  localparam logic [header-1:0] HDR_RD  = header'(1);
  localparam logic [header-1:0] HDR_WR  = header'(2);

  typedef enum logic [2:0] {
    WAIT_CS = 3'd0,
    IDLE    = 3'd1,
    SHIFT   = 3'd2,
    DATA    = 3'd3,
    DONE    = 3'd4
  } state_e;

  logic [2:0]         sclk_q;
  logic [1:0]         cs_q;
  logic [1:0]         mosi_q;
  logic [1:0]         settle_q, settle_d;
  state_e             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d, cnt_inc;
  logic [pktsz-1:0]   sin_q, sin_d, sin_next;
  logic [payload-1:0] sout_q, sout_d;
  logic [header-1:0]  hdr_q, hdr_d;
  logic [addrsz-1:0]  addr_q, addr_d;
  logic [payload-1:0] wdata_q, wdata_d;
  logic               we_q, we_d, re_q, re_d, re_dly_q;
  logic               miso_q, miso_d, oe_q, busy_q, busy_d, err_q, err_d;
  logic               cs_s, mosi_s, rise_s, fall_s;

  assign cs_s   = cs_q[1];
  assign mosi_s = mosi_q[1];
  assign rise_s = sclk_q[1] & ~sclk_q[2];
  assign fall_s = ~sclk_q[1] & sclk_q[2];

  assign sin_next = (sin_q << 1) | pktsz'(mosi_s);
  assign cnt_inc  = (cnt_q == PKT_CNT) ? cnt_q : cnt_q + 5'd1;

  // Frame decode FSM: next state and all datapath next values.
  always_comb begin
    state_d  = state_q;
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    cnt_d    = cnt_q;
    sin_d    = sin_q;
    sout_d   = sout_q;
    hdr_d    = hdr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    err_d    = 1'b0;
    miso_d   = miso_q;
    if (re_dly_q) begin
      sout_d = reg_rdata;
    end else begin
      sout_d = sout_q;
    end
    case (state_q)
      // settle_q keeps the reset value of the cs_n synchronizer from looking like a real idle bus
      WAIT_CS: begin
        if ((settle_q == 2'd2) && cs_s) state_d = IDLE;
        else                           state_d = WAIT_CS;
      end
      IDLE: begin
        if (!cs_s) begin
          state_d = SHIFT;
          cnt_d   = 5'd0;
          sout_d  = '0;
          miso_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (rise_s) begin
          cnt_d = cnt_inc;
          sin_d = sin_next;
          if (cnt_q == HA_CNT - 5'd1) begin
            hdr_d   = sin_next[header+addrsz-1:addrsz];
            addr_d  = sin_next[addrsz-1:0];
            re_d    = (sin_next[header+addrsz-1:addrsz] == HDR_RD);
            state_d = DATA;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      DATA: begin
        if (cs_s) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          if (fall_s) begin
            miso_d = sout_q[payload-1];
            sout_d = sout_q << 1;
          end else begin
            miso_d = miso_q;
          end
          if (rise_s) begin
            cnt_d = cnt_inc;
            sin_d = sin_next;
            if (cnt_inc == PKT_CNT) begin
              state_d = DONE;
              // the header/address bits must still line up with what was decoded at bit 9
              if ((hdr_q == HDR_WR) && (sin_next[pktsz-1:payload] == {hdr_q, addr_q})) begin
                we_d    = 1'b1;
                wdata_d = sin_next[payload-1:0];
              end else begin
                we_d    = 1'b0;
              end
            end else begin
              state_d = DATA;
            end
          end else begin
            state_d = DATA;
          end
        end
      end
      DONE: begin
        if (cs_s) state_d = IDLE;
        else      state_d = DONE;
      end
      default: state_d = WAIT_CS;
    endcase
    if (cs_s) begin
      miso_d = 1'b0;
    end else begin
      miso_d = miso_d;
    end
    busy_d = (state_d == SHIFT) || (state_d == DATA) || (state_d == DONE);
  end

  // Synchronizers and all state/output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_q   <= 3'b000;
      cs_q     <= 2'b11;
      mosi_q   <= 2'b00;
      settle_q <= 2'd0;
      state_q  <= WAIT_CS;
      cnt_q    <= 5'd0;
      sin_q    <= '0;
      sout_q   <= '0;
      hdr_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      re_dly_q <= 1'b0;
      miso_q   <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sclk_q   <= {sclk_q[1:0], sclk};
      cs_q     <= {cs_q[0], cs_n};
      mosi_q   <= {mosi_q[0], mosi};
      settle_q <= settle_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sin_q    <= sin_d;
      sout_q   <= sout_d;
      hdr_q    <= hdr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      re_q     <= re_d;
      re_dly_q <= re_q;
      miso_q   <= miso_d;
      oe_q     <= ~cs_s;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = oe_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed bench for spi_slave_regif: bit-bangs SPI frames at a 5-clk phase and
// checks strobes, decoded address/data and MISO read-back against hand-computed values.
module tb_spi_slave_regif;

  logic       clk = 1'b0;
  logic       reset, sclk, cs_n, mosi;
  logic       miso, miso_oe, reg_we, reg_re, busy, frame_err;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;

  int checks = 0;
  int errors = 0;
  int we_cnt, re_cnt, err_cnt;
  logic [6:0]  we_addr, re_addr;
  logic [7:0]  we_data;
  logic [16:0] rx;
  logic [7:0]  mem [0:127];

  always #5 clk = ~clk;

  spi_slave_regif dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
    .busy(busy), .frame_err(frame_err)
  );

  // Register file: read data appears the clk after reg_re.
  always @(posedge clk) begin
    if (reg_re) reg_rdata <= mem[reg_addr];
    if (reg_we) mem[reg_addr] <= reg_wdata;
  end

  // Count strobes and capture what accompanied them.
  always @(negedge clk) begin
    if (reg_we) begin
      we_cnt++;
      we_addr = reg_addr;
      we_data = reg_wdata;
    end
    if (reg_re) begin
      re_cnt++;
      re_addr = reg_addr;
    end
    if (frame_err) err_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    we_cnt = 0; re_cnt = 0; err_cnt = 0;
    we_addr = '0; re_addr = '0; we_data = '0;
  endtask

  // Master side: nrise rising edges, optional reset pulse after bit rst_at, gap clks of cs_n high.
  task automatic frame(input logic [1:0] h, input logic [6:0] a, input logic [7:0] d,
                       input int nrise, input int rst_at, input int gap);
    logic [16:0] pkt;
    pkt  = {h, a, d};
    rx   = '0;
    cs_n = 1'b0;
    wait_clk(5);
    for (int i = 0; i < nrise; i++) begin
      mosi = pkt[16-i];
      wait_clk(5);
      sclk = 1'b1;
      rx[16-i] = miso;
      wait_clk(5);
      sclk = 1'b0;
      if (i == 4) begin
        chk("busy_mid", {31'd0, busy}, 32'd1);
        chk("oe_mid", {31'd0, miso_oe}, 32'd1);
      end
      if (i + 1 == rst_at) begin
        reset = 1'b0;
        wait_clk(1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_addr", {25'd0, reg_addr}, 32'd0);
        reset = 1'b1;
      end
    end
    wait_clk(5);
    cs_n = 1'b1;
    wait_clk(gap);
  endtask

  initial begin
    reset = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; reg_rdata = 8'h00;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h2A] = 8'h3C;
    clr();
    wait_clk(3);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_reg_addr", {25'd0, reg_addr}, 32'd0);
    chk("rst_wdata", {24'd0, reg_wdata}, 32'd0);
    chk("rst_we", {31'd0, reg_we}, 32'd0);
    chk("rst_re", {31'd0, reg_re}, 32'd0);
    chk("rst_busy0", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b1;
    wait_clk(5);

    clr();
    frame(2'b10, 7'h15, 8'hA5, 17, 0, 6);
    chk("wr_we_cnt", we_cnt, 32'd1);
    chk("wr_re_cnt", re_cnt, 32'd0);
    chk("wr_err_cnt", err_cnt, 32'd0);
    chk("wr_addr", {25'd0, we_addr}, 32'h15);
    chk("wr_data", {24'd0, we_data}, 32'hA5);
    chk("wr_busy_end", {31'd0, busy}, 32'd0);
    chk("wr_oe_end", {31'd0, miso_oe}, 32'd0);

    clr();
    frame(2'b01, 7'h2A, 8'h00, 17, 0, 6);
    chk("rd_re_cnt", re_cnt, 32'd1);
    chk("rd_re_addr", {25'd0, re_addr}, 32'h2A);
    chk("rd_miso", {24'd0, rx[7:0]}, 32'h3C);
    chk("rd_we_cnt", we_cnt, 32'd0);

    clr();
    frame(2'b10, 7'h05, 8'hC3, 12, 0, 6);
    chk("ab_err_cnt", err_cnt, 32'd1);
    chk("ab_we_cnt", we_cnt, 32'd0);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    clr();
    frame(2'b10, 7'h01, 8'hFF, 17, 0, 6);
    chk("ab_next_we", we_cnt, 32'd1);
    chk("ab_next_addr", {25'd0, we_addr}, 32'h01);
    chk("ab_next_data", {24'd0, we_data}, 32'hFF);
    chk("ab_next_err", err_cnt, 32'd0);

    clr();
    frame(2'b11, 7'h7F, 8'h55, 17, 0, 6);
    chk("inv_we", we_cnt, 32'd0);
    chk("inv_re", re_cnt, 32'd0);
    chk("inv_err", err_cnt, 32'd0);
    chk("inv_miso", {24'd0, rx[7:0]}, 32'h00);

    clr();
    frame(2'b10, 7'h44, 8'h77, 17, 5, 6);
    chk("mr_we", we_cnt, 32'd0);
    chk("mr_re", re_cnt, 32'd0);
    chk("mr_err", err_cnt, 32'd0);
    clr();
    frame(2'b10, 7'h33, 8'h5A, 17, 0, 6);
    chk("mr_next_we", we_cnt, 32'd1);
    chk("mr_next_addr", {25'd0, we_addr}, 32'h33);
    chk("mr_next_data", {24'd0, we_data}, 32'h5A);

    clr();
    frame(2'b10, 7'h10, 8'h81, 17, 0, 3);
    chk("b2b_we", we_cnt, 32'd1);
    chk("b2b_addr", {25'd0, we_addr}, 32'h10);
    chk("b2b_data", {24'd0, we_data}, 32'h81);
    clr();
    frame(2'b01, 7'h10, 8'h00, 17, 0, 6);
    chk("b2b_re", re_cnt, 32'd1);
    chk("b2b_re_addr", {25'd0, re_addr}, 32'h10);
    chk("b2b_miso", {24'd0, rx[7:0]}, 32'h81);
    chk("b2b_err", err_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
